// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns single-word local commands into one AXI4-Lite read or
// write transaction at a time and returns the slave's response as a one-cycle pulse.
//
// state   | meaning
// IDLE    | ready for a command
// WR_AW_W | address and write data offered; each channel completes independently
// WR_B    | waiting for the write response
// RD_AR   | read address offered
// RD_R    | waiting for read data
// RESP    | response presented for one cycle
module axi4_lite_master #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int ADDR_WIDTH  = 32,
   localparam int WSTRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr,
   input  logic [DATA_WIDTH-1:0]  cmd_wdata,
   input  logic [WSTRB_WIDTH-1:0] cmd_wstrb,
   output logic                   rsp_valid,
   output logic                   rsp_write,
   output logic [DATA_WIDTH-1:0]  rsp_rdata,
   output logic [1:0]             rsp_resp,
   output logic                   AWVALID,
   input  logic                   AWREADY,
   output logic [ADDR_WIDTH-1:0]  AWADDR,
   output logic [2:0]             AWPROT,
   output logic                   WVALID,
   input  logic                   WREADY,
   output logic [DATA_WIDTH-1:0]  WDATA,
   output logic [WSTRB_WIDTH-1:0] WSTRB,
   input  logic                   BVALID,
   output logic                   BREADY,
   input  logic [1:0]             BRESP,
   output logic                   ARVALID,
   input  logic                   ARREADY,
   output logic [ADDR_WIDTH-1:0]  ARADDR,
   output logic [2:0]             ARPROT,
   input  logic                   RVALID,
   output logic                   RREADY,
   input  logic [DATA_WIDTH-1:0]  RDATA,
   input  logic [1:0]             RRESP
);

   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $fatal(1, "axi4_lite_master: DATA_WIDTH must be 32 or 64");
   end

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_AW_W = 3'd1,
      WR_B    = 3'd2,
      RD_AR   = 3'd3,
      RD_R    = 3'd4,
      RESP    = 3'd5
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic                   aw_done;
   logic                   w_done;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [WSTRB_WIDTH-1:0] wstrb_q;

   always_ff @(posedge ACLK) begin
      if (ARESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = cmd_write ? WR_AW_W : RD_AR;
         // READY on an already-finished channel is harmless: its VALID is low
         WR_AW_W: if ((aw_done || AWREADY) && (w_done || WREADY)) state_nxt = WR_B;
         WR_B:    if (BVALID)  state_nxt = RESP;
         RD_AR:   if (ARREADY) state_nxt = RD_R;
         RD_R:    if (RVALID)  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
      end else begin
         if (state == IDLE && cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (state == WR_AW_W) begin
            if (AWREADY) aw_done <= 1'b1;
            if (WREADY)  w_done  <= 1'b1;
         end
         if (state == WR_B && BVALID) begin
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= BRESP;
         end
         if (state == RD_R && RVALID) begin
            rsp_write <= 1'b0;
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
         end
      end
   end

   // gated by ARESET so the master never advertises readiness while held in reset
   assign cmd_ready = (state == IDLE) && !ARESET;
   assign rsp_valid = (state == RESP);
   assign AWVALID   = (state == WR_AW_W) && !aw_done;
   assign WVALID    = (state == WR_AW_W) && !w_done;
   assign BREADY    = (state == WR_B);
   assign ARVALID   = (state == RD_AR);
   assign RREADY    = (state == RD_R);
   assign AWADDR    = addr_q;
   assign ARADDR    = addr_q;
   assign WDATA     = wdata_q;
   assign WSTRB     = wstrb_q;
   assign AWPROT    = 3'b000;
   assign ARPROT    = 3'b000;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a delay-programmable slave, a timeline model of each
// transaction checked every cycle, and directed commands with literal expectations.
module tb_axi4_lite_master;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   always #5 ACLK = ~ACLK;

   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        AWVALID, AWREADY = 1'b0, WVALID, WREADY = 1'b0;
   logic [31:0] AWADDR, WDATA, ARADDR;
   logic [2:0]  AWPROT, ARPROT;
   logic [3:0]  WSTRB;
   logic        BVALID = 1'b0, BREADY, ARVALID, ARREADY = 1'b0, RVALID = 1'b0, RREADY;
   logic [1:0]  BRESP = '0, RRESP = '0;
   logic [31:0] RDATA = '0;

   axi4_lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
   );

   // 64-bit instance against an always-ready slave with BVALID held high early
   logic        q_cmd_valid = 1'b0, q_cmd_ready, q_cmd_write = 1'b0;
   logic [31:0] q_cmd_addr = '0;
   logic [63:0] q_cmd_wdata = '0;
   logic [7:0]  q_cmd_wstrb = '0;
   logic        q_rsp_valid, q_rsp_write;
   logic [63:0] q_rsp_rdata;
   logic [1:0]  q_rsp_resp;
   logic        q_AWVALID, q_WVALID, q_BREADY, q_ARVALID, q_RREADY;
   logic [31:0] q_AWADDR, q_ARADDR;
   logic [2:0]  q_AWPROT, q_ARPROT;
   logic [63:0] q_WDATA;
   logic [7:0]  q_WSTRB;
   logic        q_AWREADY = 1'b1, q_WREADY = 1'b1, q_BVALID = 1'b1, q_ARREADY = 1'b1, q_RVALID = 1'b1;
   logic [1:0]  q_BRESP = 2'b00, q_RRESP = 2'b00;
   logic [63:0] q_RDATA = '0;

   axi4_lite_master #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(q_cmd_valid), .cmd_ready(q_cmd_ready), .cmd_write(q_cmd_write),
      .cmd_addr(q_cmd_addr), .cmd_wdata(q_cmd_wdata), .cmd_wstrb(q_cmd_wstrb),
      .rsp_valid(q_rsp_valid), .rsp_write(q_rsp_write), .rsp_rdata(q_rsp_rdata), .rsp_resp(q_rsp_resp),
      .AWVALID(q_AWVALID), .AWREADY(q_AWREADY), .AWADDR(q_AWADDR), .AWPROT(q_AWPROT),
      .WVALID(q_WVALID), .WREADY(q_WREADY), .WDATA(q_WDATA), .WSTRB(q_WSTRB),
      .BVALID(q_BVALID), .BREADY(q_BREADY), .BRESP(q_BRESP),
      .ARVALID(q_ARVALID), .ARREADY(q_ARREADY), .ARADDR(q_ARADDR), .ARPROT(q_ARPROT),
      .RVALID(q_RVALID), .RREADY(q_RREADY), .RDATA(q_RDATA), .RRESP(q_RRESP)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // slave behaviour: each READY / response VALID comes after a programmed number of waits
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0]  wr_resp = 2'b00, rd_resp = 2'b00;
   logic [31:0] rd_data = '0;
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

   always @(negedge ACLK) begin
      if (AWVALID) begin AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin AWREADY = 1'b0; aw_cnt = 0; end
      if (WVALID) begin WREADY = (w_cnt >= w_dly); w_cnt++; end
      else begin WREADY = 1'b0; w_cnt = 0; end
      if (ARVALID) begin ARREADY = (ar_cnt >= ar_dly); ar_cnt++; end
      else begin ARREADY = 1'b0; ar_cnt = 0; end
      if (BREADY) begin BVALID = (b_cnt >= b_dly); b_cnt++; end
      else begin BVALID = 1'b0; b_cnt = 0; end
      if (RREADY) begin RVALID = (r_cnt >= r_dly); r_cnt++; end
      else begin RVALID = 1'b0; r_cnt = 0; end
      BRESP = wr_resp;
      RRESP = rd_resp;
      RDATA = rd_data;
   end

   // Model: a transaction is a timeline indexed by cycles since acceptance (t=1 first).
   bit          m_busy = 0, m_wr = 0, m_rst = 0;
   int          m_t = 0, m_end = 0, m_aw = 0, m_w = 0, m_b = 0, m_ar = 0, m_r = 0, m_mx = 0;
   logic [31:0] m_addr = '0, m_data = '0, m_rdata = '0;
   logic [3:0]  m_strb = '0;
   logic [1:0]  m_bresp = '0, m_rresp = '0;

   always @(posedge ACLK) begin
      bit e_awv, e_wv, e_br, e_arv, e_rr, e_rsp, e_cr;
      m_rst = ARESET;
      if (ARESET) m_busy = 0;
      else if (m_busy) begin
         m_t++;
         if (m_t > m_end) m_busy = 0;
      end else if (cmd_valid) begin
         m_busy = 1; m_t = 1; m_wr = cmd_write;
         m_addr = cmd_addr; m_data = cmd_wdata; m_strb = cmd_wstrb;
         m_aw = aw_dly; m_w = w_dly; m_b = b_dly; m_ar = ar_dly; m_r = r_dly;
         m_bresp = wr_resp; m_rresp = rd_resp; m_rdata = rd_data;
         m_mx = (m_aw > m_w) ? m_aw : m_w;
         m_end = m_wr ? 3 + m_mx + m_b : 3 + m_ar + m_r;
      end
      #1;
      e_awv = m_busy && m_wr && m_t <= 1 + m_aw;
      e_wv  = m_busy && m_wr && m_t <= 1 + m_w;
      e_br  = m_busy && m_wr && m_t >= 2 + m_mx && m_t <= 2 + m_mx + m_b;
      e_arv = m_busy && !m_wr && m_t <= 1 + m_ar;
      e_rr  = m_busy && !m_wr && m_t >= 2 + m_ar && m_t <= 2 + m_ar + m_r;
      e_rsp = m_busy && m_t == m_end;
      e_cr  = !m_busy && !m_rst;
      chk("cmd_ready", 64'(cmd_ready), 64'(e_cr));
      chk("awvalid",   64'(AWVALID),   64'(e_awv));
      chk("wvalid",    64'(WVALID),    64'(e_wv));
      chk("bready",    64'(BREADY),    64'(e_br));
      chk("arvalid",   64'(ARVALID),   64'(e_arv));
      chk("rready",    64'(RREADY),    64'(e_rr));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      chk("prot",      64'({AWPROT, ARPROT}), 64'(0));
      chk("ar_excl",   64'(ARVALID && (AWVALID || WVALID)), 64'(0));
      if (e_awv) chk("awaddr", 64'(AWADDR), 64'(m_addr));
      if (e_wv) begin
         chk("wdata", 64'(WDATA), 64'(m_data));
         chk("wstrb", 64'(WSTRB), 64'(m_strb));
      end
      if (e_arv) chk("araddr", 64'(ARADDR), 64'(m_addr));
      if (e_rsp) begin
         chk("rsp_write", 64'(rsp_write), 64'(m_wr));
         chk("rsp_rdata", 64'(rsp_rdata), m_wr ? 64'(0) : 64'(m_rdata));
         chk("rsp_resp",  64'(rsp_resp),  m_wr ? 64'(m_bresp) : 64'(m_rresp));
      end
      if (m_rst) begin
         chk("rst_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(0));
         chk("rst_regs", {AWADDR, WDATA}, 64'(0));
      end
   end

   task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
      aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
   endtask

   task automatic run_cmd(input string name, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_resp);
      int n;
      @(negedge ACLK);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
      chk({name, "_accept"}, 64'(cmd_ready), 64'(1));
      @(negedge ACLK);
      cmd_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 60) begin @(negedge ACLK); n++; end
      chk({name, "_latency"}, 64'(n), 64'(exp_lat));
      chk({name, "_write"}, 64'(rsp_write), 64'(wr));
      chk({name, "_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
      chk({name, "_resp"},  64'(rsp_resp),  64'(exp_resp));
      @(negedge ACLK);
      chk({name, "_pulse"}, 64'(rsp_valid), 64'(0));
   endtask

   initial begin
      int  k;
      bit  prev;
      #10000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int  k;
      bit  prev;
      repeat (3) @(negedge ACLK);
      chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
      ARESET = 1'b0;
      #1 chk("post_reset_cmd_ready", 64'(cmd_ready), 64'(1));

      set_dly(0, 0, 0, 0, 0); wr_resp = 2'b00;
      run_cmd("wr_zero", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 32'h0, 2'b00);

      set_dly(3, 0, 0, 0, 0);
      run_cmd("wr_skew_aw", 1'b1, 32'h24, 32'h0BADF00D, 4'h3, 6, 32'h0, 2'b00);

      set_dly(0, 2, 1, 0, 0); wr_resp = 2'b11;
      run_cmd("wr_skew_w_decerr", 1'b1, 32'h30, 32'h55AA55AA, 4'h8, 6, 32'h0, 2'b11);

      set_dly(2, 2, 0, 0, 0); wr_resp = 2'b10;
      run_cmd("wr_same_cycle", 1'b1, 32'h34, 32'h11112222, 4'hC, 5, 32'h0, 2'b10);

      set_dly(0, 0, 0, 2, 2); rd_data = 32'h12345678; rd_resp = 2'b10;
      run_cmd("rd_stall", 1'b0, 32'h44, 32'h0, 4'h0, 7, 32'h12345678, 2'b10);

      set_dly(0, 0, 0, 0, 0); rd_data = 32'hAABBCCDD; rd_resp = 2'b00;
      run_cmd("rd_zero", 1'b0, 32'h48, 32'h0, 4'h0, 3, 32'hAABBCCDD, 2'b00);

      // back-to-back: write then read with cmd_valid never dropping
      wr_resp = 2'b00; rd_data = 32'hCAFE0001;
      @(negedge ACLK);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h01020304; cmd_wstrb = 4'hF;
      k = 0;
      while (!cmd_ready && k < 50) begin @(negedge ACLK); k++; end
      @(negedge ACLK);
      cmd_write = 1'b0; cmd_addr = 32'h54;
      k = 1; prev = 1'b0;
      while (!cmd_ready && k < 20) begin prev = rsp_valid; @(negedge ACLK); k++; end
      chk("b2b_gap", 64'(k), 64'(4));
      chk("b2b_prev_rsp", 64'(prev), 64'(1));
      @(negedge ACLK);
      cmd_valid = 1'b0;
      k = 1;
      while (!rsp_valid && k < 50) begin @(negedge ACLK); k++; end
      chk("b2b_rd_latency", 64'(k), 64'(3));
      chk("b2b_rd_rdata", 64'(rsp_rdata), 64'(32'hCAFE0001));

      // reset while waiting for read data
      set_dly(0, 0, 0, 0, 6);
      @(negedge ACLK);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60;
      k = 0;
      while (!cmd_ready && k < 50) begin @(negedge ACLK); k++; end
      @(negedge ACLK);
      cmd_valid = 1'b0;
      k = 0;
      while (!RREADY && k < 20) begin @(negedge ACLK); k++; end
      chk("mid_rst_in_rd_r", 64'(RREADY), 64'(1));
      ARESET = 1'b1;
      @(negedge ACLK);
      chk("mid_rst_rready", 64'(RREADY), 64'(0));
      chk("mid_rst_valids", 64'({AWVALID, WVALID, ARVALID, rsp_valid}), 64'(0));
      chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("after_rst_cmd_ready", 64'(cmd_ready), 64'(1));
      repeat (8) @(negedge ACLK);

      // 64-bit write; BVALID already high must not complete before the B phase
      q_cmd_valid = 1'b1; q_cmd_write = 1'b1; q_cmd_addr = 32'h40;
      q_cmd_wdata = 64'h0123456789ABCDEF; q_cmd_wstrb = 8'hF0;
      chk("w64_accept", 64'(q_cmd_ready), 64'(1));
      @(negedge ACLK);
      q_cmd_valid = 1'b0;
      chk("w64_wvalid", 64'(q_WVALID), 64'(1));
      chk("w64_wdata", q_WDATA, 64'h0123456789ABCDEF);
      chk("w64_wstrb", 64'(q_WSTRB), 64'(8'hF0));
      chk("w64_awaddr", 64'(q_AWADDR), 64'(32'h40));
      @(negedge ACLK);
      chk("w64_bready", 64'(q_BREADY), 64'(1));
      chk("w64_rsp_early", 64'(q_rsp_valid), 64'(0));
      @(negedge ACLK);
      chk("w64_rsp_valid", 64'(q_rsp_valid), 64'(1));
      chk("w64_rsp_write", 64'(q_rsp_write), 64'(1));
      chk("w64_rsp_rdata", q_rsp_rdata, 64'(0));
      @(negedge ACLK);
      chk("w64_idle", 64'(q_cmd_ready), 64'(1));

      repeat (2) @(negedge ACLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
